// File: rtl/operand_fetch_pkg.sv
// Shared definitions for the operand fetch stage: opcodes, ALU select codes,
// control FSM states and the instruction word layout.
// Imported by the control block (operand_fetch) and register file.
package operand_fetch_pkg;

  // Register address width (8 general registers)
  localparam int ADDR_W = 3;

  // Opcodes; everything above OP_OR is undefined
  localparam logic [7:0] OP_LOADI = 8'h00;
  localparam logic [7:0] OP_MOV   = 8'h01;
  localparam logic [7:0] OP_ADD   = 8'h02;
  localparam logic [7:0] OP_SUB   = 8'h03;
  localparam logic [7:0] OP_AND   = 8'h04;
  localparam logic [7:0] OP_OR    = 8'h05;

  // ALU operation select codes
  localparam logic [2:0] SEL_FWD = 3'b000;  // result = operand 2
  localparam logic [2:0] SEL_ADD = 3'b001;
  localparam logic [2:0] SEL_AND = 3'b010;
  localparam logic [2:0] SEL_OR  = 3'b011;

  // Control FSM states
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DECODE = 2'd1,
    ST_EXEC   = 2'd2
  } state_t;

  // Instruction word layout; IMM overlays {rsvd_c, src2}
  typedef struct packed {
    logic [7:0]        opcode;  // [31:24]
    logic [4:0]        rsvd_a;  // [23:19]
    logic [ADDR_W-1:0] dest;    // [18:16]
    logic [4:0]        rsvd_b;  // [15:11]
    logic [ADDR_W-1:0] src1;    // [10:8]
    logic [4:0]        rsvd_c;  // [7:3]
    logic [ADDR_W-1:0] src2;    // [2:0]
  } instr_t;

endpackage

// File: rtl/operand_fetch_reg_file.sv
// General register file: REG_COUNT x DATA_WIDTH, two read ports, one debug read port, one write port.
// Latency: reads are combinational; a write lands on the rising edge with we high.
// Backpressure: none, always accepts a write.
// Ports: clk/rst (async active-high), we/waddr/wdata write port, raddr1/rdata1 and
//        raddr2/rdata2 operand read ports, dbg_addr/dbg_data debug read port.
module operand_fetch_reg_file
  import operand_fetch_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int REG_COUNT  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [ADDR_W-1:0]     waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [ADDR_W-1:0]     raddr1,
  output logic [DATA_WIDTH-1:0] rdata1,
  input  logic [ADDR_W-1:0]     raddr2,
  output logic [DATA_WIDTH-1:0] rdata2,
  input  logic [ADDR_W-1:0]     dbg_addr,
  output logic [DATA_WIDTH-1:0] dbg_data
);

  logic [DATA_WIDTH-1:0] regs [REG_COUNT];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < REG_COUNT; i++) begin
        regs[i] <= '0;
      end
    end else if (we) begin
      regs[waddr] <= wdata;
    end
  end

  assign rdata1   = regs[raddr1];
  assign rdata2   = regs[raddr2];
  assign dbg_data = regs[dbg_addr];

endmodule

// File: rtl/operand_fetch.sv
// Operand fetch stage: accepts an instruction, reads operands, drives the ALU and writes back its result.
// Latency: accept at edge N, operands registered at N+1, write-back at N+2; one instruction per 3 cycles.
// Backpressure: INSTR_READY is high only in IDLE; INSTR_VALID is ignored otherwise.
// Ports: CLK, RESET (async active-high); INSTRUCTION/INSTR_VALID/INSTR_READY instruction handshake;
//        DATA1/DATA2/SELECT to the ALU, ALU_RESULT back; ILLEGAL pulse; DBG_ADDR/DBG_DATA debug read.
module operand_fetch
  import operand_fetch_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int REG_COUNT  = 8
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic [31:0]           INSTRUCTION,
  input  logic                  INSTR_VALID,
  output logic                  INSTR_READY,
  output logic [DATA_WIDTH-1:0] DATA1,
  output logic [DATA_WIDTH-1:0] DATA2,
  output logic [2:0]            SELECT,
  input  logic [DATA_WIDTH-1:0] ALU_RESULT,
  output logic                  ILLEGAL,
  input  logic [ADDR_W-1:0]     DBG_ADDR,
  output logic [DATA_WIDTH-1:0] DBG_DATA
);

  state_t state, state_nxt;
  instr_t ir;

  logic [DATA_WIDTH-1:0] rd1, rd2, neg_rd2;
  logic [DATA_WIDTH-1:0] dec_d1, dec_d2;
  logic [2:0]            dec_sel;
  logic                  dec_legal;
  logic [7:0]            imm;

  logic accept, rf_we, load_ops, set_illegal;

  // Reserved instruction fields carry no meaning in this stage
  logic ir_unused;
  assign ir_unused = ^{ir.rsvd_a, ir.rsvd_b};

  assign accept  = INSTR_VALID & INSTR_READY;
  assign imm     = {ir.rsvd_c, ir.src2};
  // Two's-complement negation wraps, so 0x00 -> 0x00 and 0x80 -> 0x80
  assign neg_rd2 = ~rd2 + DATA_WIDTH'(1);

  // ---------------------------------------------------------------------------
  // Register file. Operands are read from IR while in DECODE, so a write at
  // the end of EXEC is always visible to the next instruction.
  // ---------------------------------------------------------------------------
  operand_fetch_reg_file #(
    .DATA_WIDTH (DATA_WIDTH),
    .REG_COUNT  (REG_COUNT)
  ) reg_file (
    .clk      (CLK),
    .rst      (RESET),
    .we       (rf_we),
    .waddr    (ir.dest),
    .wdata    (ALU_RESULT),
    .raddr1   (ir.src1),
    .rdata1   (rd1),
    .raddr2   (ir.src2),
    .rdata2   (rd2),
    .dbg_addr (DBG_ADDR),
    .dbg_data (DBG_DATA)
  );

  // ---------------------------------------------------------------------------
  // Opcode decode
  // ---------------------------------------------------------------------------
  always_comb begin
    dec_legal = 1'b1;
    dec_sel   = SEL_FWD;
    dec_d1    = '0;
    dec_d2    = '0;
    case (ir.opcode)
      OP_LOADI: dec_d2 = DATA_WIDTH'(imm);
      OP_MOV:   dec_d2 = rd2;
      OP_ADD: begin
        dec_sel = SEL_ADD;
        dec_d1  = rd1;
        dec_d2  = rd2;
      end
      OP_SUB: begin
        // Subtraction reuses the adder with a negated second operand
        dec_sel = SEL_ADD;
        dec_d1  = rd1;
        dec_d2  = neg_rd2;
      end
      OP_AND: begin
        dec_sel = SEL_AND;
        dec_d1  = rd1;
        dec_d2  = rd2;
      end
      OP_OR: begin
        dec_sel = SEL_OR;
        dec_d1  = rd1;
        dec_d2  = rd2;
      end
      default: dec_legal = 1'b0;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Control FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Control FSM: next state
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (INSTR_VALID) state_nxt = ST_DECODE;
      ST_DECODE: state_nxt = dec_legal ? ST_EXEC : ST_IDLE;
      ST_EXEC:   state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // Control FSM: outputs
  always_comb begin
    INSTR_READY = 1'b0;
    rf_we       = 1'b0;
    load_ops    = 1'b0;
    set_illegal = 1'b0;
    case (state)
      ST_IDLE:   INSTR_READY = 1'b1;
      ST_DECODE: begin
        load_ops    = dec_legal;
        set_illegal = ~dec_legal;
      end
      ST_EXEC:   rf_we = 1'b1;
      default:   ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath registers. ALU operands hold their value until the next legal
  // instruction leaves DECODE; an illegal opcode only raises ILLEGAL.
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      ir      <= '0;
      DATA1   <= '0;
      DATA2   <= '0;
      SELECT  <= SEL_FWD;
      ILLEGAL <= 1'b0;
    end else begin
      ILLEGAL <= set_illegal;
      if (accept) begin
        ir <= instr_t'(INSTRUCTION);
      end
      if (load_ops) begin
        DATA1  <= dec_d1;
        DATA2  <= dec_d2;
        SELECT <= dec_sel;
      end
    end
  end

endmodule

// File: tb/tb_operand_fetch.sv
// Directed bench for operand_fetch with a behavioural ALU attached.
// Expected register, operand and handshake values are hand-computed per vector.
// Ports driven #1 after the rising edge, sampled before the next one.
module tb_operand_fetch;

  logic        CLK = 1'b0;
  logic        RESET;
  logic [31:0] INSTRUCTION;
  logic        INSTR_VALID;
  logic        INSTR_READY;
  logic [7:0]  DATA1, DATA2;
  logic [2:0]  SELECT;
  logic [7:0]  ALU_RESULT;
  logic        ILLEGAL;
  logic [2:0]  DBG_ADDR;
  logic [7:0]  DBG_DATA;

  int checks = 0;
  int errors = 0;
  logic [7:0] mr [8];   // expected register contents

  operand_fetch #(.DATA_WIDTH(8), .REG_COUNT(8)) dut (
    .CLK         (CLK),
    .RESET       (RESET),
    .INSTRUCTION (INSTRUCTION),
    .INSTR_VALID (INSTR_VALID),
    .INSTR_READY (INSTR_READY),
    .DATA1       (DATA1),
    .DATA2       (DATA2),
    .SELECT      (SELECT),
    .ALU_RESULT  (ALU_RESULT),
    .ILLEGAL     (ILLEGAL),
    .DBG_ADDR    (DBG_ADDR),
    .DBG_DATA    (DBG_DATA)
  );

  always #5 CLK = ~CLK;

  // Attached ALU
  always_comb begin
    case (SELECT)
      3'b000:  ALU_RESULT = DATA2;
      3'b001:  ALU_RESULT = DATA1 + DATA2;
      3'b010:  ALU_RESULT = DATA1 & DATA2;
      3'b011:  ALU_RESULT = DATA1 | DATA2;
      default: ALU_RESULT = 8'h00;
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  function automatic logic [31:0] ins(input logic [7:0] op, input logic [2:0] d,
                                      input logic [2:0] s1, input logic [2:0] s2);
    return {op, 5'b0, d, 5'b0, s1, 5'b0, s2};
  endfunction

  function automatic logic [31:0] li(input logic [2:0] d, input logic [7:0] imm);
    return {8'h00, 5'b0, d, 8'h00, imm};
  endfunction

  // Present one instruction and return #1 after its accept edge
  task automatic send(input logic [31:0] w);
    int n;
    n = 0;
    INSTRUCTION = w;
    INSTR_VALID = 1'b1;
    while (!INSTR_READY && n < 10) begin
      step();
      n++;
    end
    chk("accept_rdy", INSTR_READY, 1);
    step();
    INSTR_VALID = 1'b0;
  endtask

  // Issue one instruction, check operands at N+1 and write-back at N+2
  task automatic run(input string tag, input logic [31:0] w, input logic [2:0] dst,
                     input logic [7:0] d1, input logic [7:0] d2,
                     input logic [2:0] sel, input logic [7:0] res);
    send(w);
    DBG_ADDR = dst;
    #1;
    chk({tag, ".nowrite_dec"}, DBG_DATA, mr[dst]);
    step();
    chk({tag, ".d1"}, DATA1, d1);
    chk({tag, ".d2"}, DATA2, d2);
    chk({tag, ".sel"}, SELECT, sel);
    chk({tag, ".nowrite_exec"}, DBG_DATA, mr[dst]);
    chk({tag, ".rdy_exec"}, INSTR_READY, 0);
    step();
    mr[dst] = res;
    chk({tag, ".wb"}, DBG_DATA, res);
    chk({tag, ".rdy_idle"}, INSTR_READY, 1);
  endtask

  task automatic check_regs(input string tag);
    for (int i = 0; i < 8; i++) begin
      DBG_ADDR = 3'(i);
      #1;
      chk($sformatf("%s.r%0d", tag, i), DBG_DATA, mr[i]);
    end
    step();
  endtask

  initial begin
    RESET       = 1'b1;
    INSTRUCTION = 32'h0;
    INSTR_VALID = 1'b0;
    DBG_ADDR    = 3'd0;
    for (int i = 0; i < 8; i++) mr[i] = 8'h00;

    // Reset state, before and after clock edges
    #2;
    chk("rst.rdy", INSTR_READY, 1);
    chk("rst.d1", DATA1, 8'h00);
    chk("rst.d2", DATA2, 8'h00);
    chk("rst.sel", SELECT, 3'b000);
    chk("rst.ill", ILLEGAL, 0);
    step();
    step();
    RESET = 1'b0;
    check_regs("rst");

    // loadi R1,0x05 ; loadi R2,0x07
    run("li_r1", li(3'd1, 8'h05), 3'd1, 8'h00, 8'h05, 3'b000, 8'h05);
    run("li_r2", li(3'd2, 8'h07), 3'd2, 8'h00, 8'h07, 3'b000, 8'h07);

    // sub R3,R1,R2 -> 0x05 + 0xF9 = 0xFE
    run("sub_r3", ins(8'h03, 3'd3, 3'd1, 3'd2), 3'd3, 8'h05, 8'hF9, 3'b001, 8'hFE);

    // Back-to-back add R4,R1,R2 then mov R5,R4 with INSTR_VALID held high
    INSTRUCTION = ins(8'h02, 3'd4, 3'd1, 3'd2);
    INSTR_VALID = 1'b1;
    begin
      int lows;
      lows = 0;
      for (int i = 0; i < 6; i++) begin
        step();
        if (i == 0) INSTRUCTION = ins(8'h01, 3'd5, 3'd0, 3'd4);
        if (!INSTR_READY) lows++;
        chk($sformatf("b2b.rdy%0d", i), INSTR_READY, (i % 3 == 2) ? 1 : 0);
        if (i == 5) INSTR_VALID = 1'b0;
      end
      chk("b2b.lows", lows, 4);
    end
    chk("b2b.d1", DATA1, 8'h00);
    chk("b2b.d2", DATA2, 8'h0C);
    mr[4] = 8'h0C;
    mr[5] = 8'h0C;
    check_regs("b2b");

    // Undefined opcode 0x09: one-cycle ILLEGAL, nothing else changes
    send(ins(8'h09, 3'd1, 3'd1, 3'd2));
    chk("ill.dec", ILLEGAL, 0);
    step();
    chk("ill.pulse", ILLEGAL, 1);
    chk("ill.d1", DATA1, 8'h00);
    chk("ill.d2", DATA2, 8'h0C);
    chk("ill.sel", SELECT, 3'b000);
    chk("ill.rdy", INSTR_READY, 1);
    step();
    chk("ill.end", ILLEGAL, 0);
    chk("ill.d2b", DATA2, 8'h0C);
    check_regs("ill");

    // Reset in the middle of EXEC of loadi R6,0xAA
    send(li(3'd6, 8'hAA));
    step();
    chk("rx.exec_d2", DATA2, 8'hAA);
    #2;
    RESET = 1'b1;
    DBG_ADDR = 3'd1;
    #1;
    chk("rx.rdy", INSTR_READY, 1);
    chk("rx.d1", DATA1, 8'h00);
    chk("rx.d2", DATA2, 8'h00);
    chk("rx.sel", SELECT, 3'b000);
    chk("rx.ill", ILLEGAL, 0);
    chk("rx.r1", DBG_DATA, 8'h00);
    step();
    RESET = 1'b0;
    for (int i = 0; i < 8; i++) mr[i] = 8'h00;
    chk("rx.rdy_rel", INSTR_READY, 1);
    step();
    step();
    chk("rx.d2_after", DATA2, 8'h00);
    check_regs("rx");

    // Logic ops (reserved bits set on the and), subtraction boundaries
    run("li_r1b", li(3'd1, 8'h05), 3'd1, 8'h00, 8'h05, 3'b000, 8'h05);
    run("li_r2b", li(3'd2, 8'h07), 3'd2, 8'h00, 8'h07, 3'b000, 8'h07);
    run("and_r7", ins(8'h04, 3'd7, 3'd1, 3'd2) | 32'h00F8_F8F8, 3'd7, 8'h05, 8'h07, 3'b010, 8'h05);
    run("or_r0", ins(8'h05, 3'd0, 3'd1, 3'd2), 3'd0, 8'h05, 8'h07, 3'b011, 8'h07);
    run("sub_r0", ins(8'h03, 3'd0, 3'd0, 3'd0), 3'd0, 8'h07, 8'hF9, 3'b001, 8'h00);
    run("li_r3", li(3'd3, 8'h80), 3'd3, 8'h00, 8'h80, 3'b000, 8'h80);
    run("neg80", ins(8'h03, 3'd4, 3'd3, 3'd3), 3'd4, 8'h80, 8'h80, 3'b001, 8'h00);
    run("neg00", ins(8'h03, 3'd5, 3'd1, 3'd0), 3'd5, 8'h05, 8'h00, 3'b001, 8'h05);
    check_regs("end");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/operand_fetch.md
OPERAND_FETCH -- requirements
Module: operand_fetch

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, meaning register and operand width.
REQ-002 SHALL have parameter REG_COUNT, default 8, meaning number of general registers (3-bit address).
REQ-003 SHALL have port CLK, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port RESET, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port INSTRUCTION, input, 32, instruction word: [31:24] OPCODE, [18:16] DEST, [10:8] SRC1, [2:0] SRC2, [7:0] IMM.
REQ-006 SHALL have port INSTR_VALID, input, 1, instruction present.
REQ-007 SHALL have port INSTR_READY, output, 1, stage can accept an instruction.
REQ-008 SHALL have port DATA1, output, 8, ALU operand 1.
REQ-009 SHALL have port DATA2, output, 8, ALU operand 2.
REQ-010 SHALL have port SELECT, output, 3, ALU operation (000 forward, 001 add, 010 and, 011 or).
REQ-011 SHALL have port ALU_RESULT, input, 8, combinational ALU result, settled within one CLK period.
REQ-012 SHALL have port ILLEGAL, output, 1, one-cycle pulse on undefined opcode.
REQ-013 SHALL have port DBG_ADDR, input, 3, debug register select.
REQ-014 SHALL have port DBG_DATA, output, 8, combinational R[DBG_ADDR].

Function
REQ-015 SHALL implement FSM IDLE -> DECODE -> EXEC -> IDLE; INSTR_READY = 1 only in IDLE.
REQ-016 SHALL capture INSTRUCTION into an internal IR on the edge where INSTR_VALID & INSTR_READY; otherwise SHALL remain in IDLE.
REQ-017 SHALL, on the edge leaving DECODE, register DATA1/DATA2/SELECT per opcode: 0x00 loadi (000, 0, IMM); 0x01 mov (000, 0, R[SRC2]); 0x02 add (001, R[SRC1], R[SRC2]); 0x03 sub (001, R[SRC1], (~R[SRC2]+1) mod 256); 0x04 and (010, R[SRC1], R[SRC2]); 0x05 or (011, R[SRC1], R[SRC2]).
REQ-018 SHALL ignore OPCODE values 0x06-0xFF: pulse ILLEGAL for the cycle after DECODE, leave DATA1/DATA2/SELECT and registers unchanged, return to IDLE.
REQ-019 SHALL write ALU_RESULT into R[DEST] on the edge leaving EXEC; no other register write path exists.
REQ-020 SHALL give latency: accept at edge N, operands valid after N+1, write at N+2, INSTR_READY high after N+2; throughput one instruction per 3 cycles.
REQ-021 SHALL read registers in DECODE so an instruction accepted at N+2 sees the value written at N+2 (no hazard, no forwarding logic).
REQ-022 SHALL hold DATA1/DATA2/SELECT stable between instructions.
REQ-023 SHALL perform all arithmetic modulo 2^8; negation of 0x00 yields 0x00, of 0x80 yields 0x80.
REQ-024 SHALL ignore INSTRUCTION bits [23:19], [15:11], [7:3] (IMM excepted for loadi).

Reset
REQ-025 SHALL, while RESET = 1, force state IDLE, all registers R0-R7 = 0x00, IR = 0, DATA1 = DATA2 = 0x00, SELECT = 000, ILLEGAL = 0, regardless of CLK.
REQ-026 SHALL abort any in-flight instruction on reset with no register write; INSTR_READY = 1 on the first edge after RESET falls.

Structure
REQ-027 SHALL take opcode constants, SELECT codes and FSM state encodings from a shared definitions package/header used by the ALU and control blocks.
REQ-028 SHALL instantiate one sub-module reg_file (8x8, two read ports, one debug read port, one write port, async reset).

Verification
REQ-029 Reset then loadi R1,0x05; loadi R2,0x07 -> DBG R1 = 0x05, R2 = 0x07, each write 2 cycles after accept.
REQ-030 sub R3,R1,R2 -> DATA1 = 0x05, DATA2 = 0xF9, SELECT = 001; with ALU attached, R3 = 0xFE.
REQ-031 Back-to-back add R4,R1,R2 then mov R5,R4 with INSTR_VALID held high -> R5 = 0x0C; INSTR_READY low exactly 2 of every 3 cycles.
REQ-032 Opcode 0x09 -> ILLEGAL pulse of 1 cycle; all registers and ALU outputs unchanged.
REQ-033 RESET asserted mid-EXEC of loadi R6,0xAA -> R6 = 0x00, all outputs at reset values immediately, no write after release.
REQ-034 and R7,R1,R2 then or R0,R1,R2 -> R7 = 0x05, R0 = 0x07; sub R0,R0,R0 -> R0 = 0x00.
